// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode and mux-select encodings for the multicycle MIPS control path
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_RS  = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    // One bit per supported instruction; all-zero means an illegal encoding
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
        logic addi;
    } cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: IR fields and ALU flags in, datapath enables and selects out
interface mc_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       pc_wr;
    logic       ir_wr;
    logic       rf_wr;
    logic       dm_wr;
    logic [1:0] npc_sel;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] ext_op;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       illegal;
    logic       instr_done;

    modport master (
        input  op, funct, zero, overflow,
        output pc_wr, ir_wr, rf_wr, dm_wr, npc_sel, reg_dst, wd_sel, ext_op,
               alu_src, alu_op, state, illegal, instr_done
    );

    modport slave (
        output op, funct, zero, overflow,
        input  pc_wr, ir_wr, rf_wr, dm_wr, npc_sel, reg_dst, wd_sel, ext_op,
               alu_src, alu_op, state, illegal, instr_done
    );

endinterface

// File: rtl/mc_decode.sv
// mc_decode: op/funct to one-hot instruction class plus illegal flag
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic       illegal
);

    logic rtype;

    assign rtype = op == OP_RTYPE;

    // Exactly one class bit is set for any supported encoding
    always_comb begin
        cls      = '0;
        cls.addu = rtype && funct == FN_ADDU;
        cls.subu = rtype && funct == FN_SUBU;
        cls.jr   = rtype && funct == FN_JR;
        cls.ori  = op == OP_ORI;
        cls.lw   = op == OP_LW;
        cls.sw   = op == OP_SW;
        cls.beq  = op == OP_BEQ;
        cls.lui  = op == OP_LUI;
        cls.j    = op == OP_J;
        cls.jal  = op == OP_JAL;
        cls.addi = op == OP_ADDI;
    end

    assign illegal = cls == '0;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: IF/ID/EXE/MEM/WB sequencer producing all datapath enables and selects
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input logic      clk,
    input logic      rst,
    mc_ctrl_if.master bus
);

    state_t state_q, state_d;
    logic   ov_q;
    cls_t   cls;
    logic   dec_ill;
    logic   rtype, jump, mem_op, alu_on;
    logic   pc_wr, ir_wr, rf_wr, dm_wr, ill, done;
    logic [1:0] npc_sel, reg_dst, wd_sel;

    mc_decode u_dec (
        .op      (bus.op),
        .funct   (bus.funct),
        .cls     (cls),
        .illegal (dec_ill)
    );

    assign rtype  = cls.addu | cls.subu | cls.jr;
    assign jump   = cls.j | cls.jal | cls.jr;
    assign mem_op = cls.lw | cls.sw;
    assign alu_on = state_q inside {S_EXE, S_MEM, S_WB};

    // State register; overflow is captured at the end of EXE for addi's write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXE) ov_q <= bus.overflow;
        end
    end

    // Next state and per-state enables; unreachable codes fall back to fetch
    always_comb begin
        state_d = S_IF;
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        rf_wr   = 1'b0;
        dm_wr   = 1'b0;
        ill     = 1'b0;
        done    = 1'b0;
        npc_sel = NPC_PC4;
        reg_dst = RD_RT;
        wd_sel  = WD_ALU;
        case (state_q)
            S_IF: begin
                pc_wr   = 1'b1;
                ir_wr   = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                pc_wr   = jump;
                npc_sel = cls.jr ? NPC_RS : (cls.j | cls.jal) ? NPC_J : NPC_PC4;
                rf_wr   = cls.jal;
                reg_dst = cls.jal ? RD_RA : RD_RT;
                wd_sel  = cls.jal ? WD_PC4 : WD_ALU;
                ill     = dec_ill;
                done    = jump | dec_ill;
                state_d = (jump | dec_ill) ? S_IF : S_EXE;
            end
            S_EXE: begin
                pc_wr   = cls.beq & bus.zero;
                npc_sel = cls.beq ? NPC_BR : NPC_PC4;
                done    = cls.beq;
                state_d = cls.beq ? S_IF : mem_op ? S_MEM : S_WB;
            end
            S_MEM: begin
                dm_wr   = cls.sw;
                done    = cls.sw;
                state_d = cls.lw ? S_WB : S_IF;
            end
            S_WB: begin
                rf_wr   = cls.addi ? ~ov_q : 1'b1;
                reg_dst = rtype ? RD_RD : RD_RT;
                wd_sel  = cls.lw ? WD_DM : WD_ALU;
                done    = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    assign bus.alu_op  = !alu_on ? ALU_ADD : (cls.subu | cls.beq) ? ALU_SUB :
                         (cls.ori | cls.lui) ? ALU_OR : ALU_ADD;
    assign bus.alu_src = alu_on & (cls.ori | cls.lui | cls.addi | mem_op);
    assign bus.ext_op  = !alu_on ? EXT_ZERO : cls.lui ? EXT_LUI :
                         (cls.addi | mem_op) ? EXT_SIGN : EXT_ZERO;

    assign bus.pc_wr      = pc_wr & ~rst;
    assign bus.ir_wr      = ir_wr & ~rst;
    assign bus.rf_wr      = rf_wr & ~rst;
    assign bus.dm_wr      = dm_wr & ~rst;
    assign bus.illegal    = ill & ~rst;
    assign bus.instr_done = done & ~rst;
    assign bus.npc_sel    = npc_sel;
    assign bus.reg_dst    = reg_dst;
    assign bus.wd_sel     = wd_sel;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench; stimulus queues expected output vectors, monitor compares each cycle
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stim_done = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [20:0] exp_q[$];
    string       name_q[$];
    logic [20:0] act;

    mc_ctrl_if bus();

    mc_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign act = {bus.state, bus.pc_wr, bus.ir_wr, bus.rf_wr, bus.dm_wr, bus.npc_sel,
                  bus.reg_dst, bus.wd_sel, bus.ext_op, bus.alu_src, bus.alu_op,
                  bus.illegal, bus.instr_done};

    function automatic logic [20:0] ev(input logic [2:0] st, input logic pc, ir, rf, dm,
                                       input logic [1:0] npc, rd, wd, ext,
                                       input logic asrc, input logic [2:0] aop,
                                       input logic ill, done);
        return {st, pc, ir, rf, dm, npc, rd, wd, ext, asrc, aop, ill, done};
    endfunction

    // Monitor: every cycle the DUT presents a full output vector; compare against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [20:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end else if (stim_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic step(input logic [20:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string nm, input logic [5:0] o, f, input logic z, v, input int n,
                       input logic [20:0] a, b, c, d);
        logic [20:0] e[4];
        e = '{a, b, c, d};
        bus.op = o;
        bus.funct = f;
        bus.zero = z;
        bus.overflow = v;
        step(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), {nm, "_if"});
        for (int i = 0; i < n - 1; i++) step(e[i], $sformatf("%s_c%0d", nm, i + 1));
    endtask

    initial begin
        logic [20:0] id0, exe_ls, mem_ls, x;
        id0    = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exe_ls = ev(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        mem_ls = ev(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        x      = '0;
        bus.op = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;
        bus.overflow = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_a");
        step(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_b");
        rst = 1'b0;
        run("lw", 6'b100011, 6'b000000, 0, 0, 5, id0, exe_ls, mem_ls,
            ev(4, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        run("sw", 6'b101011, 6'b000000, 0, 0, 4, id0, exe_ls,
            ev(3, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1), x);
        run("beq_t", 6'b000100, 6'b000000, 1, 0, 3, id0,
            ev(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1), x, x);
        run("beq_n", 6'b000100, 6'b000000, 0, 0, 3, id0,
            ev(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1), x, x);
        run("jal", 6'b000011, 6'b000000, 0, 0, 2,
            ev(1, 1, 0, 1, 0, 2, 2, 2, 0, 0, 0, 0, 1), x, x, x);
        run("jr", 6'b000000, 6'b001000, 0, 0, 2,
            ev(1, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1), x, x, x);
        run("j", 6'b000010, 6'b000000, 0, 0, 2,
            ev(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1), x, x, x);
        run("addi_ov", 6'b001000, 6'b000000, 0, 1, 4, id0, exe_ls,
            ev(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), x);
        run("addi_ok", 6'b001000, 6'b000000, 0, 0, 4, id0, exe_ls,
            ev(4, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1), x);
        run("addu_ov", 6'b000000, 6'b100001, 0, 1, 4, id0,
            ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            ev(4, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1), x);
        run("subu", 6'b000000, 6'b100011, 1, 1, 4, id0,
            ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
            ev(4, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1), x);
        run("ori", 6'b001101, 6'b000000, 0, 0, 4, id0,
            ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0),
            ev(4, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1), x);
        run("lui", 6'b001111, 6'b000000, 0, 0, 4, id0,
            ev(2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0),
            ev(4, 0, 0, 1, 0, 0, 0, 0, 2, 1, 2, 0, 1), x);
        run("ill_op", 6'b111111, 6'b000000, 0, 0, 2,
            ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), x, x, x);
        run("ill_fn", 6'b000000, 6'b000000, 0, 0, 2,
            ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), x, x, x);
        run("sw_rst", 6'b101011, 6'b000000, 0, 0, 3, id0, exe_ls, x, x);
        rst = 1'b1;
        step(ev(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "sw_rst_mem");
        step(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_rst_after");
        rst = 1'b0;
        run("post_rst", 6'b000010, 6'b000000, 0, 0, 2,
            ev(1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1), x, x, x);
        stim_done = 1'b1;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit for the `mips` CPU. It sequences the shared datapath (PC, IR, register file, ALU, data memory) through fetch, decode, execute, memory and write-back. Each instruction takes 2–5 cycles. It decodes `op`/`funct` from the IR and produces every write enable and mux select. It also tracks ALU overflow so that `addi` suppresses its write-back on overflow.

## Interface
- No parameters; all encodings come from `mc_ctrl_pkg`.
- `clk` in 1: the only clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 6: IR[31:26]; the IR holds it stable from ID onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU equal flag, valid in EXE.
- `overflow` in 1: ALU signed-overflow flag, valid in EXE.
- `pc_wr` out 1: PC load enable.
- `ir_wr` out 1: IR load enable.
- `rf_wr` out 1: register-file write enable.
- `dm_wr` out 1: data-memory write enable.
- `npc_sel` out 2: next-PC source. 00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs (`jr`).
- `reg_dst` out 2: write-register select. 00 = rt, 01 = rd, 10 = $31.
- `wd_sel` out 2: write-data select. 00 = ALU result, 01 = DM data, 10 = PC+4.
- `ext_op` out 2: immediate extension. 00 = zero-extend, 01 = sign-extend, 10 = shift left 16 (`lui`).
- `alu_src` out 1: ALU B operand. 0 = register, 1 = extended immediate.
- `alu_op` out 3: 000 = add, 001 = sub, 010 = or.
- `state` out 3: current state, for debug.
- `illegal` out 1: one-cycle pulse in ID for an unsupported encoding.
- `instr_done` out 1: one-cycle pulse in an instruction's final cycle.

## Operation
**Supported instructions** (`op`/`funct`, binary):
- R-type, `op` 000000: `addu` (`funct` 100001), `subu` (100011), `jr` (001000).
- `ori` 001101, `lw` 100011, `sw` 101011, `beq` 000100.
- `lui` 001111, `j` 000010, `jal` 000011, `addi` 001000.

**States:** S_IF = 0, S_ID = 1, S_EXE = 2, S_MEM = 3, S_WB = 4. Codes 5–7 are unreachable and recover to S_IF on the next edge.

**Transitions:**
- **S_IF:** `pc_wr`=1, `ir_wr`=1, `npc_sel`=00. Next state is S_ID.
- **S_ID:**
  - `j`: `pc_wr`=1, `npc_sel`=10. Next state S_IF.
  - `jal`: `pc_wr`=1, `npc_sel`=10, `rf_wr`=1, `reg_dst`=10, `wd_sel`=10. Next state S_IF.
  - `jr`: `pc_wr`=1, `npc_sel`=11. Next state S_IF.
  - Illegal encoding: pulse `illegal`, no writes. Next state S_IF.
  - All other instructions: next state S_EXE.
- **S_EXE:** ALU controls are driven from the decoded class:
  - `addu`: `alu_op`=add, `alu_src`=0.
  - `subu`: `alu_op`=sub, `alu_src`=0.
  - `ori`: `alu_op`=or, `alu_src`=1, `ext_op`=00.
  - `lui`: `alu_op`=or, `alu_src`=1, `ext_op`=10 (operand rs = $0 by ISA).
  - `addi`, `lw`, `sw`: `alu_op`=add, `alu_src`=1, `ext_op`=01.
  - `beq`: `alu_op`=sub, `pc_wr`=`zero`, `npc_sel`=01. Next state S_IF.
  - `lw`, `sw`: next state S_MEM. All others: next state S_WB.
  - On this edge, `ov_q` <= `overflow`.
- **S_MEM:**
  - `sw`: `dm_wr`=1. Next state S_IF.
  - `lw`: next state S_WB.
- **S_WB:** write-back, then next state S_IF.
  - `rf_wr`=1; for `addi`, `rf_wr`=~`ov_q`.
  - `reg_dst`: 01 for R-type, otherwise 00.
  - `wd_sel`: 01 for `lw`, otherwise 00.

**Output rules:**
- Outputs are combinational from `state`, the decoded class, `zero` and `ov_q`.
- Unlisted outputs are 0. The EXE ALU selects are held through MEM and WB.

## Timing
- **Reset:**
  - While `rst`=1, all enables (`pc_wr`, `ir_wr`, `rf_wr`, `dm_wr`), `illegal` and `instr_done` are forced to 0.
  - The `state` register is loaded with S_IF, and `ov_q` is cleared to 0.
  - The first cycle after `rst` falls is S_IF, which fetches.
- **Reset mid-instruction:** the instruction is abandoned with no partial writes after the reset edge.
- **CPI:**
  - `j`, `jal`, `jr` and illegal encodings: 2.
  - `beq`: 3.
  - `addu`, `subu`, `ori`, `lui`, `addi`, `sw`: 4.
  - `lw`: 5.
- **`instr_done`** pulses in S_ID for jumps and illegal encodings, in S_EXE for `beq`, in S_MEM for `sw`, and in S_WB otherwise.
- **Boundary cases:**
  - `beq` with `zero`=0: `pc_wr`=0; the PC already holds PC+4 from IF.
  - `overflow` is ignored for every instruction except `addi`; `addu` and `subu` always write.
- `op`/`funct` are sampled only combinationally. Any change outside S_IF is an upstream IR bug; there is no checking for it.

## Structure
- **`mc_ctrl_pkg`:** state enum, opcode/funct constants, and the `npc_sel`/`reg_dst`/`wd_sel`/`ext_op`/`alu_op` encodings. The datapath muxes share this package.
- **`mc_decode` sub-module:** combinational `op`/`funct` to one-hot instruction class plus `illegal`. `mc_ctrl_fsm` holds the state register, `ov_q` and the output logic.

## Test plan
- **Reset:** hold `rst` 3 cycles with `op`=100011 → all enables 0, `state`=0. Release → IF cycle with `pc_wr`=`ir_wr`=1.
- **`lw` (100011):** state sequence 0,1,2,3,4. In WB, `rf_wr`=1, `wd_sel`=01, `reg_dst`=00. `instr_done` only in WB. Then `sw` (101011): `dm_wr`=1 in MEM only, 4 cycles.
- **`beq` (000100):** with `zero`=1 → EXE `pc_wr`=1, `npc_sel`=01, 3 cycles. With `zero`=0 → `pc_wr`=0 in EXE.
- **Jumps:** `jal` (000011) → ID has `pc_wr`=`rf_wr`=1, `reg_dst`=10, `wd_sel`=10, 2 cycles. `jr` (000000/001000) → `npc_sel`=11.
- **`addi` (001000):** `overflow`=1 in EXE → WB `rf_wr`=0. `overflow`=0 → `rf_wr`=1. `addu` with `overflow`=1 → `rf_wr`=1.
- **Illegal and reset mid-instruction:** `op`=111111 → `illegal` pulse in ID, no writes, back to IF. Assert `rst` during MEM of `sw` → `dm_wr`=0 and `state`=0 next cycle.
